// File: rtl/uart_tx_param_if.sv
// Host-side handshake bundle for the parametrised UART transmitter.
// The host drives tx_valid/tx_data; the transmitter answers with tx_ready.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// 1 or 2 stop bits, with bit timing taken from an external 1x baud tick.
module uart_tx_param #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    uart_tx_param_if.slave      bus,
    input  logic                baud_tick_1x,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx_line
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

    typedef enum logic [2:0] {
        IDLE, READY, START, DATA, PARITY, STOP
    } state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_reg;
    logic [CNT_W-1:0]  bit_cnt_reg;
    logic [1:0]        stop_cnt_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              line_reg;
    logic              accept;

    assign accept       = bus.tx_valid & ready_reg;
    assign bus.tx_ready = ready_reg;
    assign tx_busy      = busy_reg;
    assign tx_done      = done_reg;
    assign tx_line      = line_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            line_reg     <= 1'b1;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b0;
                    line_reg  <= 1'b1;
                    if (en) begin
                        state_reg <= READY;
                        ready_reg <= 1'b1;
                    end
                end

                READY: begin
                    // A handshake already offered by tx_ready is honoured even if en drops
                    // in the same cycle; the frame then completes and the block idles.
                    if (accept) begin
                        shift_reg   <= bus.tx_data;
                        parity_reg  <= (^bus.tx_data) ^ (PARITY_ODD != 0);
                        busy_reg    <= 1'b1;
                        ready_reg   <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= START;
                    end else if (!en) begin
                        ready_reg <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end

                START: begin
                    // The line is still high until the first tick; the second tick ends the start bit.
                    if (baud_tick_1x) begin
                        if (line_reg) begin
                            line_reg <= 1'b0;
                        end else begin
                            line_reg    <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_cnt_reg <= CNT_W'(1);
                            state_reg   <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (baud_tick_1x) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                line_reg  <= parity_reg;
                                state_reg <= PARITY;
                            end else begin
                                line_reg     <= 1'b1;
                                stop_cnt_reg <= 2'd1;
                                state_reg    <= STOP;
                            end
                        end else begin
                            line_reg    <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (baud_tick_1x) begin
                        line_reg     <= 1'b1;
                        stop_cnt_reg <= 2'd1;
                        state_reg    <= STOP;
                    end
                end

                STOP: begin
                    if (baud_tick_1x) begin
                        if (stop_cnt_reg == LAST_STOP) begin
                            done_reg <= 1'b1;
                            busy_reg <= 1'b0;
                            if (en) begin
                                ready_reg <= 1'b1;
                                state_reg <= READY;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            stop_cnt_reg <= stop_cnt_reg + 2'd1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    line_reg  <= 1'b1;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) share clock, reset and tick;
// stimulus queues expected frames/probes and a negedge monitor captures the line and compares.
module tb_uart_tx_param;
    localparam int N       = 4;
    localparam int F_LINE  = 0;
    localparam int F_BUSY  = 1;
    localparam int F_READY = 2;
    localparam int F_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       en_a    [N];
    logic       valid_a [N];
    logic       ready_a [N];
    logic       busy_a  [N];
    logic       done_a  [N];
    logic       line_a  [N];
    logic [8:0] data_a  [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int DW = (gi == 3) ? 7 : 8;
        uart_tx_param_if #(.DATA_W(DW)) bus ();
        assign bus.tx_valid = valid_a[gi];
        assign bus.tx_data  = data_a[gi][DW-1:0];
        assign ready_a[gi]  = bus.tx_ready;

        uart_tx_param #(
            .DATA_W     (DW),
            .PARITY_EN  ((gi == 1 || gi == 2) ? 1 : 0),
            .PARITY_ODD ((gi == 2) ? 1 : 0),
            .STOP_BITS  ((gi == 3) ? 2 : 1)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .en           (en_a[gi]),
            .bus          (bus),
            .baud_tick_1x (tick),
            .tx_busy      (busy_a[gi]),
            .tx_done      (done_a[gi]),
            .tx_line      (line_a[gi])
        );
    end

    // One-clk tick every 16 clocks, changed just after the rising edge.
    int tick_cnt = 0;
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt = (tick_cnt + 1) % 16;
            tick     = (tick_cnt == 0);
        end
    end

    typedef struct {
        int          inst;
        logic [15:0] bits;
        int          len;
        int          gap;
        int          rdy;
    } frame_t;

    typedef struct {
        int   inst;
        int   field;
        logic val;
    } probe_t;

    frame_t frame_q [$];
    probe_t probe_q [$];
    int     checks = 0;
    int     errors = 0;
    bit     finish_req = 1'b0;

    logic [15:0] cap_bits   [N];
    int          cap_len    [N];
    bit          cap_on     [N];
    bit          pend       [N];
    logic        prev_line  [N];
    bit          glitch     [N];
    int          since_done [N];
    int          cap_gap    [N];
    frame_t      f;
    probe_t      p;
    logic        act;
    string       pname;

    always @(negedge clk) begin
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.field)
                F_LINE:  begin act = line_a[p.inst];  pname = "tx_line";  end
                F_BUSY:  begin act = busy_a[p.inst];  pname = "tx_busy";  end
                F_READY: begin act = ready_a[p.inst]; pname = "tx_ready"; end
                default: begin act = done_a[p.inst];  pname = "tx_done";  end
            endcase
            checks++;
            if (act !== p.val) begin
                errors++;
                $display("FAIL probe_%s inst %0d at %0t: got %b, required %b", pname, p.inst, $time, act, p.val);
            end
        end

        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                cap_on[i]     = 1'b0;
                pend[i]       = 1'b0;
                glitch[i]     = 1'b0;
                since_done[i] = 0;
            end else begin
                if (done_a[i]) begin
                    checks++;
                    if (frame_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done inst %0d at %0t: got tx_done=1, required no pulse", i, $time);
                    end else begin
                        f = frame_q.pop_front();
                        if (f.inst != i || !cap_on[i] || cap_len[i] != f.len || cap_bits[i] !== f.bits) begin
                            errors++;
                            $display("FAIL frame inst %0d at %0t: got bits=%h len=%0d, required inst %0d bits=%h len=%0d",
                                     i, $time, cap_bits[i], cap_len[i], f.inst, f.bits, f.len);
                        end
                        checks++;
                        if (glitch[i] || busy_a[i] !== 1'b0) begin
                            errors++;
                            $display("FAIL frame_timing inst %0d: got mid-bit change/busy drop=%0d busy_at_done=%b, required 0 and 0",
                                     i, glitch[i], busy_a[i]);
                        end
                        checks++;
                        if (int'(ready_a[i]) != f.rdy) begin
                            errors++;
                            $display("FAIL ready_at_done inst %0d: got %b, required %0d", i, ready_a[i], f.rdy);
                        end
                        if (f.gap >= 0) begin
                            checks++;
                            if (cap_gap[i] != f.gap) begin
                                errors++;
                                $display("FAIL start_gap inst %0d: got %0d ticks after done, required %0d", i, cap_gap[i], f.gap);
                            end
                        end
                    end
                    cap_on[i]     = 1'b0;
                    since_done[i] = 0;
                end else if (pend[i]) begin
                    if (cap_on[i]) begin
                        if (cap_len[i] < 16) cap_bits[i][cap_len[i]] = line_a[i];
                        cap_len[i]++;
                    end else begin
                        since_done[i]++;
                        if (line_a[i] == 1'b0) begin
                            cap_on[i]   = 1'b1;
                            cap_bits[i] = 16'h0;
                            cap_len[i]  = 1;
                            cap_gap[i]  = since_done[i];
                            glitch[i]   = 1'b0;
                        end
                    end
                end else if (cap_on[i]) begin
                    if (line_a[i] !== prev_line[i] || busy_a[i] !== 1'b1) glitch[i] = 1'b1;
                end
                pend[i] = tick;
            end
            prev_line[i] = line_a[i];
        end

        if (finish_req) begin
            checks++;
            if (frame_q.size() != 0) begin
                errors++;
                $display("FAIL frames_pending: got %0d outstanding frames, required 0", frame_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
            $finish;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input int inst, input int field, input logic val);
        probe_q.push_back('{inst, field, val});
    endtask

    task automatic expect_frame(input int inst, input logic [15:0] bits, input int len, input int gap, input int rdy);
        frame_q.push_back('{inst, bits, len, gap, rdy});
    endtask

    // Returns just after the edge on which the word was taken; tx_valid is left high.
    task automatic accept(input int i, input logic [8:0] d);
        valid_a[i] = 1'b1;
        data_a[i]  = d;
        for (int k = 0; k < 200; k++) begin
            if (ready_a[i]) break;
            cyc(1);
        end
        cyc(1);
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 400; k++) begin
            cyc(1);
            if (done_a[i]) break;
        end
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        for (int k = 0; k < 2000 && c < n; k++) begin
            @(posedge clk);
            if (tick) c++;
        end
        #1;
    endtask

    task automatic send(input int i, input logic [8:0] d, input logic [15:0] bits, input int len);
        expect_frame(i, bits, len, -1, 1);
        accept(i, d);
        valid_a[i] = 1'b0;
        data_a[i]  = ~d;
        wait_done(i);
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            en_a[i]    = 1'b0;
            valid_a[i] = 1'b0;
            data_a[i]  = 9'h0;
        end
        cyc(3);
        for (int i = 0; i < N; i++) begin
            probe(i, F_LINE, 1'b1);
            probe(i, F_BUSY, 1'b0);
            probe(i, F_DONE, 1'b0);
            probe(i, F_READY, 1'b0);
        end
        cyc(1);
        for (int i = 0; i < N; i++) en_a[i] = 1'b1;
        rst_n = 1'b1;
        cyc(3);
        for (int i = 0; i < N; i++) probe(i, F_READY, 1'b1);
        cyc(1);

        // 8N1: start, data LSB first, stop -> bit i of the expected word is the i-th line bit.
        send(0, 9'h0A5, 16'h34A, 10);
        send(0, 9'h000, 16'h200, 10);
        send(0, 9'h0FF, 16'h3FE, 10);
        // 8E1 and 8O1
        send(1, 9'h007, 16'h60E, 11);
        send(1, 9'h003, 16'h406, 11);
        send(2, 9'h007, 16'h40E, 11);
        send(2, 9'h003, 16'h606, 11);
        // 7N2
        send(3, 9'h055, 16'h3AA, 10);
        send(3, 9'h00F, 16'h31E, 10);

        // Back-to-back with tx_valid held high.
        expect_frame(0, 16'h222, 10, -1, 1);
        expect_frame(0, 16'h244, 10, 1, 1);
        accept(0, 9'h011);
        data_a[0] = 9'h05A;
        wait_done(0);
        data_a[0] = 9'h022;
        cyc(1);
        probe(0, F_READY, 1'b0);
        probe(0, F_BUSY, 1'b1);
        valid_a[0] = 1'b0;
        wait_done(0);
        cyc(1);

        // en dropped during data bits: frame completes, then idle and deaf to tx_valid.
        expect_frame(0, 16'h386, 10, -1, 0);
        accept(0, 9'h0C3);
        valid_a[0] = 1'b0;
        wait_ticks(3);
        en_a[0] = 1'b0;
        wait_done(0);
        cyc(1);
        probe(0, F_READY, 1'b0);
        probe(0, F_BUSY, 1'b0);
        valid_a[0] = 1'b1;
        data_a[0]  = 9'h099;
        cyc(40);
        probe(0, F_READY, 1'b0);
        probe(0, F_BUSY, 1'b0);
        probe(0, F_LINE, 1'b1);
        valid_a[0] = 1'b0;
        en_a[0]    = 1'b1;
        cyc(3);
        probe(0, F_READY, 1'b1);
        cyc(1);

        // Reset during data bit 3 of 8'hF0 (that bit is 0): abort, line high at once, no tx_done.
        accept(0, 9'h0F0);
        valid_a[0] = 1'b0;
        wait_ticks(5);
        cyc(2);
        probe(0, F_LINE, 1'b0);
        probe(0, F_BUSY, 1'b1);
        cyc(1);
        rst_n = 1'b0;
        probe(0, F_LINE, 1'b1);
        probe(0, F_BUSY, 1'b0);
        probe(0, F_READY, 1'b0);
        probe(0, F_DONE, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        probe(0, F_READY, 1'b1);
        probe(0, F_LINE, 1'b1);
        cyc(300);

        finish_req = 1'b1;
        cyc(5);
        $display("FAIL monitor did not finish the run");
        $fatal(1);
    end
endmodule
